// File: rtl/mean_filter_pipe.sv
// 3x3 mean filter: capture -> 9-pixel sum -> divide (approx 7/64 or exact /9), per channel.
// Optional MEANF_PIX_CNT_EN adds the out_count output-transfer counter.
module mean_filter_pipe #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [9*CHANNELS*DATA_W-1:0] in_win,
  input  logic                         in_mode,
  input  logic                         in_sof,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_pix,
  output logic                         out_sof
`ifdef MEANF_PIX_CNT_EN
  ,
  output logic [31:0]                  out_count
`endif
);

  localparam int SW    = DATA_W + 4;
  localparam int K     = SW + 4;
  localparam int MW    = K - 2;
  localparam int PRODW = SW + MW;
  // ceil(2^K/9); the reciprocal error times any biased sum stays below 2^K, so the quotient is exact
  localparam logic [MW-1:0] RECIP = MW'(((64'd1 << K) + 64'd8) / 64'd9);

  logic                              v1, v2, v3;
  logic                              mode1, mode2;
  logic                              sof1, sof2, sof3;
  logic [9*CHANNELS*DATA_W-1:0]      win1;
  logic [CHANNELS-1:0][SW-1:0]       sum_c, sum2;
  logic [CHANNELS-1:0][DATA_W-1:0]   res_c, pix3;
  logic                              stall;

  assign out_valid = v3 && !rst;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_pix   = rst ? '0 : pix3;
  assign out_sof   = sof3 && !rst;

  always_comb begin
    sum_c = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned k = 0; k < 9; k++) begin
        sum_c[c] = sum_c[c] + SW'(win1[(c*9+k)*DATA_W +: DATA_W]);
      end
    end
  end

  always_comb begin
    res_c = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (mode2)
        res_c[c] = DATA_W'(((PRODW'(sum2[c]) + PRODW'(4)) * PRODW'(RECIP)) >> K);
      else
        res_c[c] = DATA_W'((sum2[c] >> 3) - (sum2[c] >> 6));
    end
  end

  // Data registers load only with a valid beat so idle input never reaches out_pix
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      mode1 <= 1'b0;
      mode2 <= 1'b0;
      sof1  <= 1'b0;
      sof2  <= 1'b0;
      sof3  <= 1'b0;
      win1  <= '0;
      sum2  <= '0;
      pix3  <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        win1  <= in_win;
        mode1 <= in_mode;
        sof1  <= in_sof;
      end
      if (v1) begin
        sum2  <= sum_c;
        mode2 <= mode1;
        sof2  <= sof1;
      end
      if (v2) begin
        pix3 <= res_c;
        sof3 <= sof2;
      end
    end
  end

`ifdef MEANF_PIX_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (out_valid && out_ready)
      cnt <= out_sof ? 32'd1 : cnt + 32'd1;
  end

  assign out_count = rst ? '0 : cnt;
`endif

endmodule
